// File: rtl/n_bit_alu_pkg.sv
// Shared opcode encodings and helpers for the fixed-function N-bit ALU.
package n_bit_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    function automatic string op_name(input logic [1:0] op);
        case (op)
            OP_ADD:  return "ADD";
            OP_OR:   return "OR";
            OP_SUB:  return "SUB";
            OP_XOR:  return "XOR";
            default: return "UNK";
        endcase
    endfunction

endpackage

// File: rtl/n_bit_alu_if.sv
// Operand/result bundle for one ALU instance.
interface n_bit_alu_if #(
    parameter int N = 4
);
    logic [N-1:0] in0;
    logic [N-1:0] in1;
    logic [N-1:0] out;

    modport master (output in0, output in1, input out);
    modport slave  (input in0, input in1, output out);
endinterface

// File: rtl/n_bit_alu_core.sv
// Combinational operator; only the operator chosen by OPCODE is built.
module n_bit_alu_core
    import n_bit_alu_pkg::*;
#(
    parameter int         N      = 4,
    parameter logic [1:0] OPCODE = OP_OR
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    // Add/sub wrap modulo 2^N because the sum is truncated to N bits.
    generate
        case (OPCODE)
            OP_ADD: begin : g_add
                assign y = a + b;
            end
            OP_OR: begin : g_or
                assign y = a | b;
            end
            OP_SUB: begin : g_sub
                assign y = a - b;
            end
            default: begin : g_xor
                assign y = a ^ b;
            end
        endcase
    endgenerate

endmodule

// File: rtl/n_bit_alu.sv
// Fixed-function N-bit ALU: combinational core followed by one result register.
module n_bit_alu
    import n_bit_alu_pkg::*;
#(
    parameter int         N      = 4,
    parameter logic [1:0] OPCODE = OP_OR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    output logic [N-1:0] out
);

    generate
        if (N < 1 || N > 64) begin : g_bad_width
            $error("n_bit_alu: N=%0d outside legal range 1..64", N);
        end
    endgenerate

    logic [N-1:0] core_y_s;
    logic [N-1:0] out_r;

    n_bit_alu_core #(
        .N      (N),
        .OPCODE (OPCODE)
    ) u_core (
        .a (in0),
        .b (in1),
        .y (core_y_s)
    );

    // Result register; reset clears it without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= {N{1'b0}};
        end else begin
            out_r <= core_y_s;
        end
    end

    assign out = out_r;

endmodule

// File: tb/tb_n_bit_alu.sv
// Scoreboard bench driving seven ALU instances (various widths/opcodes) in parallel.
module tb_n_bit_alu;
    import n_bit_alu_pkg::*;

    localparam int NI = 7;

    function automatic int n_of(input int g);
        case (g)
            3:       return 8;
            4:       return 1;
            5, 6:    return 64;
            default: return 4;
        endcase
    endfunction

    function automatic logic [1:0] op_of(input int g);
        case (g)
            1, 6:    return OP_ADD;
            2:       return OP_SUB;
            3:       return OP_XOR;
            default: return OP_OR;
        endcase
    endfunction

    // Reference: plain modular arithmetic on the spec's rules.
    function automatic logic [63:0] ref_op(input logic [1:0] op, input int n,
                                           input logic [63:0] x, input logic [63:0] y);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        x = x & mask;
        y = y & mask;
        case (op)
            OP_ADD:  r = x + y;
            OP_OR:   r = x | y;
            OP_SUB:  r = x - y;
            default: r = x ^ y;
        endcase
        return r & mask;
    endfunction

    typedef struct packed {
        logic [31:0]           due;
        logic [NI-1:0][63:0]   exp;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] a [NI];
    logic [63:0] b [NI];
    wire  [63:0] outs [NI];
    item_t       sb [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < NI; g++) begin : u
            localparam int NW = n_of(g);
            n_bit_alu_if #(.N(NW)) bus ();
            n_bit_alu #(.N(NW), .OPCODE(op_of(g))) dut (
                .clk   (clk),
                .rst_n (rst_n),
                .in0   (bus.in0),
                .in1   (bus.in1),
                .out   (bus.out)
            );
            assign bus.in0 = a[g][NW-1:0];
            assign bus.in1 = b[g][NW-1:0];
            assign outs[g] = 64'(bus.out);
        end
    endgenerate

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push();
        item_t it;
        it.due = 32'(cyc + 1);
        for (int g = 0; g < NI; g++) it.exp[g] = ref_op(op_of(g), n_of(g), a[g], b[g]);
        sb.push_back(it);
    endtask

    task automatic randomize_inputs();
        for (int g = 0; g < NI; g++) begin
            a[g] = {$urandom(), $urandom()};
            b[g] = {$urandom(), $urandom()};
        end
    endtask

    // Monitor: zero during reset, otherwise pop and compare results due this cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int g = 0; g < NI; g++)
                check($sformatf("rst_%s_n%0d", op_name(op_of(g)), n_of(g)), outs[g], 64'd0);
        end else begin
            while (sb.size() > 0 && sb[0].due <= 32'(cyc)) begin
                item_t it;
                it = sb.pop_front();
                for (int g = 0; g < NI; g++)
                    check($sformatf("%s_n%0d_c%0d", op_name(op_of(g)), n_of(g), it.due),
                          outs[g], it.exp[g]);
            end
        end
    end

    initial begin
        for (int g = 0; g < NI; g++) begin
            a[g] = {64{1'b1}};
            b[g] = {64{1'b1}};
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        push();

        @(posedge clk); #1;
        a[0] = 64'hA; b[0] = 64'h5;
        a[1] = 64'hF; b[1] = 64'h1;
        a[2] = 64'd3; b[2] = 64'd5;
        a[3] = 64'hCC; b[3] = 64'hAA;
        a[4] = 64'h1; b[4] = 64'h1;
        a[5] = {64{1'b1}}; b[5] = {64{1'b1}};
        a[6] = {64{1'b1}}; b[6] = {64{1'b1}};
        push();

        @(posedge clk); #1;
        randomize_inputs();
        a[1] = 64'd3; b[1] = 64'd4;
        a[2] = 64'd9; b[2] = 64'd9;
        push();

        repeat (24) begin
            @(posedge clk); #1;
            randomize_inputs();
            push();
        end

        @(posedge clk); #1;
        randomize_inputs();
        a[3] = 64'hCC; b[3] = 64'hAA;
        push();
        @(posedge clk); #1;
        randomize_inputs();
        a[3] = 64'hCC; b[3] = 64'hAA;
        push();

        // Mid-stream reset between edges must clear outputs at once.
        @(posedge clk); #1;
        check("pre_reset_xor", outs[3], 64'h66);
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        for (int g = 0; g < NI; g++) check($sformatf("async_clr_%0d", g), outs[g], 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            randomize_inputs();
        end

        @(posedge clk); #1 rst_n = 1'b1;
        randomize_inputs();
        push();
        repeat (8) begin
            @(posedge clk); #1;
            randomize_inputs();
            push();
        end

        @(posedge clk);
        @(negedge clk); #1;
        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
